// File: rtl/key_pulser_pkg.sv
// Shared constants and helpers for the key_pulser input-conditioning block.
package key_pulser_pkg;

  // Counter width shared with the pulse stretcher.
  localparam int CNT_WIDTH = 26;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_MAX = {CNT_WIDTH{1'b1}};

  // Saturating increment: the counter holds at its maximum instead of wrapping.
  function automatic cnt_t cnt_inc(input cnt_t value);
    return (value == CNT_MAX) ? value : value + cnt_t'(1);
  endfunction

  // Terminal count for a cycle count n (n >= 1); n = 0 maps to 0.
  function automatic cnt_t cnt_last(input int unsigned n);
    return (n == 0) ? cnt_t'(0) : cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/key_pulser_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage resynchronisation; both stages clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_pulser.sv
// Debounces a raw key level and emits one-cycle press pulses, with optional
// auto-repeat while the key stays held.
module key_pulser
  import key_pulser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TIME = 4,
  parameter int unsigned REPEAT_DELAY  = 0,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  output logic pulse_out,
  output logic level_out
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  localparam cnt_t DEB_LAST  = cnt_last(DEBOUNCE_TIME);
  localparam cnt_t DLY_LAST  = cnt_last(REPEAT_DELAY);
  localparam cnt_t PER_LAST  = cnt_last(REPEAT_PERIOD);
  localparam bit   REPEAT_EN = (REPEAT_DELAY != 0);

  logic   key_sync;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   repeating_q, repeating_d;
  logic   pulse_q, pulse_d;
  logic   level_q, level_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (signal_in),
    .q_o (key_sync)
  );

  // Next-state and next-output decode; the FSM only ever looks at the
  // synchronized level. Pulses default low so each one lasts one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    repeating_d = repeating_q;
    pulse_d     = 1'b0;
    level_d     = level_q;

    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (key_sync) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end

      PRESS_CHK: begin
        if (!key_sync) begin
          // Too short to be a press: drop it silently.
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = HELD;
          pulse_d     = 1'b1;
          level_d     = 1'b1;
          cnt_d       = '0;
          repeating_d = 1'b0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      HELD: begin
        if (!key_sync) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end else if (REPEAT_EN &&
                     (cnt_q == (repeating_q ? PER_LAST : DLY_LAST))) begin
          // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
          pulse_d     = 1'b1;
          cnt_d       = '0;
          repeating_d = 1'b1;
        end else begin
          // Saturates when auto-repeat is off and the key is held forever.
          cnt_d = cnt_inc(cnt_q);
        end
      end

      RELEASE_CHK: begin
        if (key_sync) begin
          // Release bounce: back to held, restart repeat timing, keep the
          // repeat phase so the next repeat uses the short period.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      repeating_q <= 1'b0;
      pulse_q     <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      repeating_q <= repeating_d;
      pulse_q     <= pulse_d;
      level_q     <= level_d;
    end
  end

  assign pulse_out = pulse_q;
  assign level_out = level_q;

endmodule

// File: tb/tb_key_pulser.sv
// Self-checking bench for key_pulser: one plain instance (no auto-repeat) and
// one auto-repeat instance, driven by hand sequences and a segment table.
// Expected pulse edges and level checkpoints are queued ahead of time and
// compared by per-instance monitors on the falling clock edge.
module tb_key_pulser;

  localparam int D  = 4;   // debounce time for both instances
  localparam int RD = 6;   // repeat delay of the repeat instance
  localparam int RP = 3;   // repeat period of the repeat instance

  logic clk = 1'b0;
  logic rst;
  logic sig_a, sig_r;
  logic pulse_a, level_a, pulse_r, level_r;

  int cyc = 0;      // number of rising edges seen so far
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   edge_n;
    logic val;
  } lvl_exp_t;

  typedef struct {
    logic lvl;        // level applied to signal_in
    int   len;        // number of edges it is sampled for
    logic exp_pulse;  // press pulse expected D+2 edges after segment start
    logic exp_level;  // level_out two edges after the segment's last sample
  } vec_t;

  int       pq_a[$];
  int       pq_r[$];
  lvl_exp_t lq_a[$];
  lvl_exp_t lq_r[$];
  vec_t     tbl[13];

  key_pulser #(.DEBOUNCE_TIME(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .signal_in (sig_a),
    .pulse_out (pulse_a),
    .level_out (level_a)
  );

  key_pulser #(.DEBOUNCE_TIME(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_r (
    .clk       (clk),
    .rst       (rst),
    .signal_in (sig_r),
    .pulse_out (pulse_r),
    .level_out (level_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d, want %0d", name, cyc, act, exp);
    end else begin
      $display("ok   %s @edge %0d: %0d", name, cyc, act);
    end
  endtask

  // Wait until the falling edge that follows rising edge e.
  task automatic goto(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Monitor for the plain instance.
  always @(negedge clk) begin
    if (pq_a.size() > 0 && pq_a[0] == cyc) begin
      void'(pq_a.pop_front());
      chk("a.pulse", {31'd0, pulse_a}, 32'd1);
    end else if (pulse_a !== 1'b0) begin
      chk("a.no_pulse", {31'd0, pulse_a}, 32'd0);
    end
    if (lq_a.size() > 0 && lq_a[0].edge_n <= cyc) begin
      chk("a.level", {31'd0, level_a}, {31'd0, lq_a[0].val});
      chk("a.level_edge", lq_a[0].edge_n, cyc);
      void'(lq_a.pop_front());
    end
  end

  // Monitor for the auto-repeat instance.
  always @(negedge clk) begin
    if (pq_r.size() > 0 && pq_r[0] == cyc) begin
      void'(pq_r.pop_front());
      chk("r.pulse", {31'd0, pulse_r}, 32'd1);
    end else if (pulse_r !== 1'b0) begin
      chk("r.no_pulse", {31'd0, pulse_r}, 32'd0);
    end
    if (lq_r.size() > 0 && lq_r[0].edge_n <= cyc) begin
      chk("r.level", {31'd0, level_r}, {31'd0, lq_r[0].val});
      chk("r.level_edge", lq_r[0].edge_n, cyc);
      void'(lq_r.pop_front());
    end
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, edge %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;

    // Segments for the plain instance (it starts the table pressed).
    tbl[0]  = '{1'b0,  8, 1'b0, 1'b0};  // long release
    tbl[1]  = '{1'b1,  2, 1'b0, 1'b0};  // press glitch
    tbl[2]  = '{1'b0,  3, 1'b0, 1'b0};
    tbl[3]  = '{1'b1,  5, 1'b1, 1'b1};  // exactly D+1 samples: accepted
    tbl[4]  = '{1'b0,  4, 1'b0, 1'b1};  // D samples: release rejected
    tbl[5]  = '{1'b1,  3, 1'b0, 1'b1};
    tbl[6]  = '{1'b0,  5, 1'b0, 1'b0};  // exactly D+1 samples: released
    tbl[7]  = '{1'b1,  4, 1'b0, 1'b0};  // D samples: press rejected
    tbl[8]  = '{1'b0,  6, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 12, 1'b1, 1'b1};
    tbl[10] = '{1'b0,  1, 1'b0, 1'b1};  // single-cycle release bounce
    tbl[11] = '{1'b1,  6, 1'b0, 1'b1};  // no second press pulse
    tbl[12] = '{1'b0, 10, 1'b0, 1'b0};

    rst   = 1'b1;
    sig_a = 1'b0;
    sig_r = 1'b0;

    // Reset state.
    goto(2);
    chk("reset.pulse_a", {31'd0, pulse_a}, 32'd0);
    chk("reset.level_a", {31'd0, level_a}, 32'd0);
    chk("reset.pulse_r", {31'd0, pulse_r}, 32'd0);
    chk("reset.level_r", {31'd0, level_r}, 32'd0);
    goto(3);
    rst = 1'b0;

    // Clean press on both: first 1 sampled at edge 10.
    goto(9);
    sig_a = 1'b1;
    sig_r = 1'b1;
    pq_a.push_back(10 + D + 2);
    lq_a.push_back('{10 + D + 1, 1'b0});
    lq_a.push_back('{10 + D + 2, 1'b1});
    // Repeat instance: HELD at 16, repeats at 16+RD then every RP edges while
    // the FSM still sees the key high (last high sample 39 is seen at edge 41).
    pq_r.push_back(10 + D + 2);
    for (int e = 10 + D + 2 + RD; e <= 41; e += RP) pq_r.push_back(e);
    lq_r.push_back('{10 + D + 2, 1'b1});

    // Repeat instance released: first 0 sampled at edge 40.
    goto(39);
    sig_r = 1'b0;
    lq_r.push_back('{40 + D + 1, 1'b1});
    lq_r.push_back('{40 + D + 2, 1'b0});

    // Plain instance released: first 0 sampled at edge 50.
    goto(49);
    sig_a = 1'b0;
    lq_a.push_back('{50 + D + 1, 1'b1});
    lq_a.push_back('{50 + D + 2, 1'b0});

    // Plain: 3-cycle glitch (samples 60..62). Repeat: new press at 60.
    goto(59);
    sig_a = 1'b1;
    sig_r = 1'b1;
    lq_a.push_back('{62, 1'b0});
    lq_a.push_back('{64, 1'b0});
    lq_a.push_back('{66, 1'b0});
    lq_a.push_back('{68, 1'b0});
    pq_r.push_back(60 + D + 2);
    pq_r.push_back(60 + D + 2 + RD);
    pq_r.push_back(60 + D + 2 + RD + RP);
    lq_r.push_back('{60 + D + 2, 1'b1});
    goto(62);
    sig_a = 1'b0;

    // Plain: a clean press after the glitch proves the FSM is idle again.
    goto(69);
    sig_a = 1'b1;
    pq_a.push_back(70 + D + 2);
    lq_a.push_back('{70 + D + 1, 1'b0});
    lq_a.push_back('{70 + D + 2, 1'b1});

    // Repeat: release bounce, low for samples 76,77, high again from 78.
    // Back in HELD at edge 80 with the repeat phase kept: next pulse 80+RP.
    goto(75);
    sig_r = 1'b0;
    goto(77);
    sig_r = 1'b1;
    for (int e = 80 + RP; e <= 91; e += RP) pq_r.push_back(e);
    lq_r.push_back('{79, 1'b1});
    lq_r.push_back('{80, 1'b1});
    lq_r.push_back('{81, 1'b1});

    // Plain: release with first 0 at edge 80.
    goto(79);
    sig_a = 1'b0;
    lq_a.push_back('{80 + D + 1, 1'b1});
    lq_a.push_back('{80 + D + 2, 1'b0});

    // Repeat: release with first 0 at edge 90, no pulse on release.
    goto(89);
    sig_r = 1'b0;
    lq_r.push_back('{90 + D + 1, 1'b1});
    lq_r.push_back('{90 + D + 2, 1'b0});

    // Repeat: press again (sample 97) so it is held when reset hits.
    goto(96);
    sig_r = 1'b1;
    pq_r.push_back(97 + D + 2);
    lq_r.push_back('{97 + D + 2, 1'b1});

    // Plain: press from sample 100; after edge 104 its counter is 2.
    goto(99);
    sig_a = 1'b1;

    // Asynchronous reset between edges 104 and 105.
    goto(104);
    rst   = 1'b1;
    sig_a = 1'b0;
    sig_r = 1'b0;
    #1;
    chk("async_rst.level_r", {31'd0, level_r}, 32'd0);
    chk("async_rst.pulse_r", {31'd0, pulse_r}, 32'd0);
    chk("async_rst.level_a", {31'd0, level_a}, 32'd0);
    chk("async_rst.pulse_a", {31'd0, pulse_a}, 32'd0);
    goto(106);
    rst = 1'b0;
    lq_a.push_back('{120, 1'b0});
    lq_r.push_back('{120, 1'b0});

    // Reset released with the key already pressed: treated as a new press.
    goto(130);
    rst   = 1'b1;
    sig_a = 1'b1;
    goto(132);
    rst = 1'b0;
    pq_a.push_back(133 + D + 2);
    lq_a.push_back('{133 + D + 1, 1'b0});
    lq_a.push_back('{133 + D + 2, 1'b1});

    // Table-driven segments on the plain instance.
    s = 150;
    for (int i = 0; i < 13; i++) begin
      goto(s - 1);
      sig_a = tbl[i].lvl;
      if (tbl[i].exp_pulse) pq_a.push_back(s + D + 2);
      lq_a.push_back('{s + tbl[i].len + 1, tbl[i].exp_level});
      s += tbl[i].len;
    end
    goto(s + 10);

    // Every queued expectation must have been consumed.
    chk("drain.pq_a", pq_a.size(), 32'd0);
    chk("drain.lq_a", lq_a.size(), 32'd0);
    chk("drain.pq_r", pq_r.size(), 32'd0);
    chk("drain.lq_r", lq_r.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
